// File: rtl/avmm_slave_pkg.sv
// Shared types and helpers for the Avalon-MM sample/result buffer slave.
package avmm_slave_pkg;

    typedef enum logic [1:0] {
        INIT,
        READY,
        STALL
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        err;
        logic [29:0] idx;
    } decode_t;

    // Byte address to word index; flags misaligned, below-base and past-end accesses.
    function automatic decode_t addr_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
        logic [31:0] off;
        decode_t     d;
        off   = addr - base;
        d.idx = off[31:2];
        d.err = (off[1:0] != 2'b00) || (addr < base) || ({2'b00, off[31:2]} >= depth);
        return d;
    endfunction

endpackage

// File: rtl/avmm_rd_delay.sv
// Fixed-latency return pipe for read data. Each stage's data only moves with a
// valid token, so the final stage holds the last returned word between returns.
// out_valid doubles as the pending-read decrement for the parent.
module avmm_rd_delay #(
    parameter int unsigned LAT = 2,
    parameter int unsigned DW  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [LAT-1:0] vld;
    logic [DW-1:0]  dat [LAT];

    // Shift valid tokens every cycle and carry data alongside them; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/avmm_sample_slave.sv
// Avalon-MM pipelined slave memory with fixed read latency, a bound on
// outstanding reads, programmable post-command stall and access statistics.
module avmm_sample_slave
    import avmm_slave_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [31:0] BASE     = 32'h0000_7000,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned MAX_PEND = 4,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    input  logic [3:0]  stall_cycles,
    input  logic        clear_stats,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PEND + 1);

    state_t         state, state_nxt;
    logic [AW-1:0]  init_idx;
    logic [3:0]     stall_ctr, stall_ctr_nxt;
    logic [PW-1:0]  pending;
    decode_t        dec;
    logic           idx_unused;
    logic           cmd_acc, rd_acc, wr_acc, both_acc;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata, rd_word;
    logic           rd_valid;
    logic [31:0]    rd_data;
    logic [31:0]    mem [DEPTH];

    assign dec        = addr_decode(s_address, BASE, 32'(DEPTH));
    assign idx_unused = ^dec.idx[29:AW];

    // A return leaving the pipe this cycle frees a slot, so a full pipe can still accept.
    assign s_waitrequest = !rst_n || (state != READY) ||
                           ((pending == PW'(MAX_PEND)) && !rd_valid);

    assign cmd_acc  = (s_read | s_write) & ~s_waitrequest;
    assign rd_acc   = cmd_acc & s_read & ~s_write;
    assign wr_acc   = cmd_acc & s_write & ~s_read;
    assign both_acc = cmd_acc & s_read & s_write;

    // Next-state logic: zero-fill sweep, then serve commands with optional forced stall.
    always_comb begin
        state_nxt     = state;
        stall_ctr_nxt = stall_ctr;
        case (state)
            INIT: begin
                if (init_idx == AW'(DEPTH - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (cmd_acc && (stall_cycles != 4'd0)) begin
                    state_nxt     = STALL;
                    stall_ctr_nxt = stall_cycles;
                end
            end
            STALL: begin
                if (stall_ctr <= 4'd1) begin
                    state_nxt = READY;
                end else begin
                    stall_ctr_nxt = stall_ctr - 4'd1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // State, sweep pointer and stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            init_idx  <= '0;
            stall_ctr <= '0;
        end else begin
            state     <= state_nxt;
            stall_ctr <= stall_ctr_nxt;
            if (state == INIT) begin
                init_idx <= init_idx + 1'b1;
            end
        end
    end

    // Outstanding-read count: up on read acceptance, down on each return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (rd_acc && !rd_valid) begin
            pending <= pending + 1'b1;
        end else if (!rd_acc && rd_valid) begin
            pending <= pending - 1'b1;
        end
    end

    // Statistics; clearing wins over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_stats) begin
            rd_count   <= '0;
            wr_count   <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (rd_acc) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_acc) begin
                wr_count <= wr_count + 16'd1;
            end
            if (cmd_acc && (both_acc || dec.err)) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign mem_we    = rst_n && ((state == INIT) || (wr_acc && !dec.err));
    assign mem_waddr = (state == INIT) ? init_idx : dec.idx[AW-1:0];
    assign mem_wdata = (state == INIT) ? 32'h0 : s_writedata;
    assign rd_word   = dec.err ? ERR_DATA : mem[dec.idx[AW-1:0]];

    // Single write port shared by the zero-fill sweep and accepted writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    avmm_rd_delay #(
        .LAT (READ_LAT),
        .DW  (32)
    ) u_rd_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

    assign s_readdatavalid = rst_n & rd_valid;
    assign s_readdata      = rd_data;

endmodule
